// File: rtl/sprscan_pkg.sv
// sprscan_pkg: shared constants, FIFO entry layout and scan FSM states
package sprscan_pkg;
  localparam int SPR_COUNT = 64;
  localparam int LINE_W = 320;
  typedef struct packed {
    logic [8:0] x;
    logic [9:0] idx;
    logic [3:0] row;
    logic [4:0] attr;
  } spr_entry_t;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/sprscan_fifo.sv
// sprscan_fifo: first-word-fall-through FIFO of sprite entries with synchronous flush
module sprscan_fifo
  import sprscan_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  spr_entry_t din,
  output spr_entry_t dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  spr_entry_t mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      if (do_push) mem[wr] <= din;
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/sprite_line_scan.sv
// sprite_line_scan: per-line sprite evaluator feeding a FWFT FIFO; SPRSCAN_XCULL_EN culls sprites off-screen right
module sprite_line_scan
  import sprscan_pkg::*;
#(
  parameter int MAX_PER_LINE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_start,
  input  logic [7:0] line_y,
  output logic [5:0] spr_sel,
  input  logic [8:0] spr_x,
  input  logic [7:0] spr_y,
  input  logic [9:0] spr_idx,
  input  logic       spr_priority,
  input  logic [1:0] spr_palette,
  input  logic       spr_h16,
  input  logic       spr_vflip,
  input  logic       spr_hflip,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] out_x,
  output logic [9:0] out_idx,
  output logic [3:0] out_row,
  output logic [4:0] out_attr,
  output logic       busy,
  output logic       scan_done,
  output logic       overflow
);
  state_t state;
  logic [7:0] cur_y, dy;
  logic [6:0] count;
  logic [3:0] row;
  logic hit, off, room, full, empty, pop, push, resolved, flush;
  spr_entry_t din, head;
  assign dy = cur_y - spr_y;
  assign row = spr_vflip ? (spr_h16 ? 4'd15 : 4'd7) - dy[3:0] : dy[3:0];
`ifdef SPRSCAN_XCULL_EN
  assign off = spr_x >= 9'(LINE_W) && spr_x <= 9'd503;
`else
  assign off = 1'b0;
`endif
  assign hit = state == SCAN && !off && dy < (spr_h16 ? 8'd16 : 8'd8);
  assign room = count < 7'(MAX_PER_LINE);
  assign pop = !empty && out_ready;
  assign push = hit && room && !line_start && (!full || pop);
  assign resolved = state == SCAN && (!hit || !room || !full || pop);
  assign flush = line_start && state != IDLE;
  assign din = '{x: spr_x, idx: spr_idx, row: row, attr: {spr_priority, spr_palette, spr_hflip, spr_h16}};
  assign out_valid = !empty;
  assign out_x = head.x;
  assign out_idx = head.idx;
  assign out_row = head.row;
  assign out_attr = head.attr;
  assign busy = state == SCAN;
  sprscan_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(flush),
    .din(din),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cur_y <= '0;
      spr_sel <= '0;
      count <= '0;
      overflow <= 1'b0;
      scan_done <= 1'b0;
    end else if (line_start) begin
      state <= SCAN;
      cur_y <= line_y;
      spr_sel <= '0;
      count <= '0;
      overflow <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (state == DONE) state <= IDLE;
      if (resolved) begin
        spr_sel <= spr_sel + 6'd1;
        count <= count + 7'(push);
        overflow <= overflow | (hit && !room);
        if (spr_sel == 6'(SPR_COUNT - 1)) begin
          state <= DONE;
          scan_done <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_sprite_line_scan.sv
// tb_sprite_line_scan: randomized scoreboard bench for sprite_line_scan against a per-line reference model
`timescale 1ns/1ps
module tb_sprite_line_scan;
  logic clk = 0, reset = 0, line_start = 0, out_ready = 0;
  logic [7:0] line_y = 0;
  logic [5:0] spr_sel;
  logic [8:0] spr_x, out_x;
  logic [7:0] spr_y;
  logic [9:0] spr_idx, out_idx;
  logic spr_priority, spr_h16, spr_vflip, spr_hflip;
  logic [1:0] spr_palette;
  logic out_valid, busy, scan_done, overflow;
  logic [3:0] out_row;
  logic [4:0] out_attr;
  logic [8:0] tx [64];
  logic [7:0] ty [64];
  logic [9:0] ti [64];
  logic tp [64], th [64], tv [64], tf [64];
  logic [1:0] tpal [64];
  logic [27:0] exp_q [$];
  logic exp_ov = 0;
  logic rnd_ready = 0, force_ready = 0;
  int checks = 0, errors = 0, done_cnt = 0, n;
  assign spr_x = tx[spr_sel];
  assign spr_y = ty[spr_sel];
  assign spr_idx = ti[spr_sel];
  assign spr_priority = tp[spr_sel];
  assign spr_palette = tpal[spr_sel];
  assign spr_h16 = th[spr_sel];
  assign spr_vflip = tv[spr_sel];
  assign spr_hflip = tf[spr_sel];
  sprite_line_scan #(.MAX_PER_LINE(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .line_y(line_y), .spr_sel(spr_sel),
    .spr_x(spr_x), .spr_y(spr_y), .spr_idx(spr_idx), .spr_priority(spr_priority),
    .spr_palette(spr_palette), .spr_h16(spr_h16), .spr_vflip(spr_vflip), .spr_hflip(spr_hflip),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_idx(out_idx),
    .out_row(out_row), .out_attr(out_attr), .busy(busy), .scan_done(scan_done), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  // Reference: walk the sprite table in index order applying the visibility rules directly.
  function automatic void model(input logic [7:0] ly);
    int cnt = 0;
    exp_ov = 0;
    for (int s = 0; s < 64; s++) begin
      int dy = (int'(ly) - int'(ty[s]) + 256) % 256;
      int h = th[s] ? 16 : 8;
      bit culled = 0;
`ifdef SPRSCAN_XCULL_EN
      culled = tx[s] >= 320 && tx[s] <= 503;
`endif
      if (dy < h && !culled) begin
        if (cnt < 16) begin
          cnt++;
          exp_q.push_back({tx[s], ti[s], 4'(tv[s] ? h - 1 - dy : dy), tp[s], tpal[s], tf[s], th[s]});
        end else exp_ov = 1;
      end
    end
  endfunction
  always @(negedge clk)
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_entry actual=%0h required=none", {out_x, out_idx, out_row, out_attr});
      end else chk("entry", {4'h0, out_x, out_idx, out_row, out_attr}, {4'h0, exp_q.pop_front()});
    end
  always @(negedge clk) if (scan_done) done_cnt++;
  initial forever begin
    @(posedge clk);
    #2;
    out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : force_ready;
  end
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic clear_table();
    for (int s = 0; s < 64; s++) begin
      ty[s] = 8'd200;
      tx[s] = 9'($urandom_range(0, 319));
      ti[s] = 10'($urandom);
      tp[s] = 1'($urandom);
      tpal[s] = 2'($urandom);
      tf[s] = 1'($urandom);
      th[s] = 0;
      tv[s] = 0;
    end
  endtask
  task automatic start_line(input logic [7:0] y);
    model(y);
    line_y = y;
    line_start = 1;
    tick(1);
    line_start = 0;
  endtask
  task automatic wait_done(output int lat);
    lat = 1;
    while (!scan_done && lat < 3000) begin
      tick(1);
      lat++;
    end
    if (!scan_done) begin
      checks++;
      errors++;
      $display("FAIL scan_done_timeout actual=0 required=1");
    end
  endtask
  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
      tick(1);
      t++;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_valid", out_valid, 0);
  endtask
  initial begin
    clear_table();
    tick(3);
    chk("rst_sel", spr_sel, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", scan_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_x", out_x, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_row", out_row, 0);
    chk("rst_attr", out_attr, 0);
    reset = 1;
    tick(2);
    // single sprite, latency of a full unstalled scan
    ty[5] = 8'd100;
    force_ready = 1;
    start_line(8'd103);
    wait_done(n);
    chk("done_latency", n, 65);
    chk("done_busy", busy, 0);
    chk("done_ovf", overflow, 0);
    drain();
    // vflipped 16-high sprite reached through Y wrap
    clear_table();
    ty[7] = 8'd250;
    th[7] = 1;
    tv[7] = 1;
    start_line(8'd4);
    wait_done(n);
    drain();
    // every sprite visible: limit and overflow
    for (int s = 0; s < 64; s++) ty[s] = 8'd0;
    start_line(8'd0);
    wait_done(n);
    chk("all_ovf", overflow, exp_ov);
    chk("all_ovf_set", overflow, 1);
    drain();
    // FIFO full stall holds the selector on the pending hit
    clear_table();
    ty[2] = 60; ty[9] = 60; ty[40] = 60; ty[41] = 60; ty[42] = 60;
    force_ready = 0;
    start_line(8'd62);
    tick(60);
    chk("stall_sel", spr_sel, 42);
    chk("stall_busy", busy, 1);
    chk("stall_valid", out_valid, 1);
    force_ready = 1;
    wait_done(n);
    drain();
    // abort mid-scan after overflow
    for (int s = 0; s < 64; s++) ty[s] = 8'd0;
    start_line(8'd0);
    tick(19);
    chk("abort_pre_ovf", overflow, 1);
    force_ready = 0;
    exp_q.delete();
    done_cnt = 0;
    start_line(8'd3);
    chk("abort_valid", out_valid, 0);
    chk("abort_ovf", overflow, 0);
    chk("abort_sel", spr_sel, 0);
    chk("abort_busy", busy, 1);
    force_ready = 1;
    wait_done(n);
    tick(2);
    chk("abort_done_cnt", done_cnt, 1);
    chk("abort_ovf_end", overflow, exp_ov);
    drain();
    // X culling boundary
    clear_table();
    ty[3] = 8'd10; tx[3] = 9'd320;
    ty[12] = 8'd8; tx[12] = 9'd504;
    start_line(8'd10);
    wait_done(n);
    drain();
    // randomized lines with random backpressure
    rnd_ready = 1;
    for (int l = 0; l < 10; l++) begin
      logic [7:0] ly = 8'($urandom);
      for (int s = 0; s < 64; s++) begin
        ty[s] = $urandom_range(0, 1) ? ly - 8'($urandom_range(0, 17)) : 8'($urandom);
        tx[s] = 9'($urandom_range(0, 511));
        ti[s] = 10'($urandom);
        tp[s] = 1'($urandom);
        tpal[s] = 2'($urandom);
        tf[s] = 1'($urandom);
        th[s] = 1'($urandom);
        tv[s] = 1'($urandom);
      end
      start_line(ly);
      wait_done(n);
      chk("rnd_ovf", overflow, exp_ov);
      drain();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
